// File: rtl/debug_dump_tx_pkg.sv
// debug_dump_tx_pkg: shared constants, state encodings and byte helper for the debug dump link.
//   HEADER_BYTE  first byte of every frame (excluded from the checksum)
//   FRAME_BYTES  header + PC + INSTR + 32 register words + checksum
//   CNT_W        byte counter width, sized to hold FRAME_BYTES
//   frame_state_e / bit_state_e  frame-level and bit-level FSM encodings
package debug_dump_tx_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 138;
    localparam int CNT_W = $clog2(FRAME_BYTES);

    typedef enum logic [2:0] {
        F_IDLE,
        F_HDR,
        F_PC,
        F_INS,
        F_REGS,
        F_CSUM
    } frame_state_e;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } bit_state_e;

    // Little-endian byte idx of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [31:0] s;
        s = w >> {idx, 3'b000};
        return s[7:0];
    endfunction

endpackage

// File: rtl/debug_dump_tx_serializer.sv
// uart_tx_serializer: 8N1 LSB-first byte serializer with its own baud counter.
//   clk_i      system clock
//   reset_i    asynchronous active-high reset (tx_o returns to 1 at once)
//   byte_in_i  byte to send, taken when load_i & ready_o
//   load_i     load request
//   ready_o    high when idle, or on the last cycle of a stop bit so the next
//              start bit follows with no idle gap
//   stop_o     high on the first cycle of each stop bit
//   tx_o       registered serial line, idles at 1
module uart_tx_serializer
    import debug_dump_tx_pkg::*;
#(
    parameter int BAUD_DIV = 1042
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] byte_in_i,
    input  logic       load_i,
    output logic       ready_o,
    output logic       stop_o,
    output logic       tx_o
);

    bit_state_e  state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  bit_q, bit_d;
    logic        tx_q, tx_d;
    logic        tc;

    assign tc = baud_q == 16'(BAUD_DIV - 1);
    assign tx_o = tx_q;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        baud_d  = (state_q == B_IDLE || tc) ? '0 : baud_q + 16'd1;
        ready_o = state_q == B_IDLE || (state_q == B_STOP && tc);
        stop_o  = state_q == B_STOP && baud_q == '0;
        if (ready_o && load_i) begin
            state_d = B_START;
            sh_d    = byte_in_i;
        end else if (tc) begin
            unique case (state_q)
                B_START: begin
                    state_d = B_DATA;
                    bit_d   = '0;
                end
                B_DATA: begin
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = B_STOP;
                end
                B_STOP: state_d = B_IDLE;
                default: ;
            endcase
        end
        // Line level is derived from the next state so tx_q lines up with the bit it encodes.
        tx_d = state_d == B_START ? 1'b0 : state_d == B_DATA ? sh_d[0] : 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= B_IDLE;
            baud_q  <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: streams one processor-state frame (header, PC, instruction,
// registers, XOR checksum) over an 8N1 UART line on a dump request.
//   clk_i       system clock
//   reset_i     asynchronous active-high reset, aborts any frame in flight
//   start_i     dump request, accepted when busy_o is low
//   pc_i        PC, captured on accepted start
//   instr_i     IF/ID instruction, captured on accepted start
//   reg_sel_o   register index requested from the register file
//   reg_data_i  register word for reg_sel_o
//   tx_o        serial line, idles at 1
//   busy_o      high from accepted start until the final stop bit ends
//   done_o      one-cycle pulse on the last cycle of the final stop bit
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int         BAUD_DIV = 1042,
    parameter int         NUM_REGS = 32,
    parameter logic [7:0] HEADER   = HEADER_BYTE
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [4:0]  reg_sel_o,
    input  logic [31:0] reg_data_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [CNT_W-3:0] LAST_WORD = (CNT_W-2)'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] REG_LAST  = {LAST_WORD, 2'b11};

    frame_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d, ins_q, ins_d, word_q, word_d;
    logic [7:0]       csum_q, csum_d, byte_d;
    logic [4:0]       sel_q, sel_d;
    logic             load, ready, stop, accept;

    assign reg_sel_o = sel_q;

    // state_q names the byte currently on the line; each ready picks the next one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        word_d  = word_q;
        sel_d   = sel_q;
        byte_d  = HEADER;
        load    = 1'b0;
        done_o  = state_q == F_CSUM && ready;
        busy_o  = state_q != F_IDLE && !done_o;
        accept  = start_i && !busy_o;
        // Next register word is latched while the last byte of the current word is in its stop bit.
        if (stop && cnt_q[1:0] == 2'd3 && (state_q == F_INS || state_q == F_REGS)) word_d = reg_data_i;
        if (ready) begin
            load  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                F_HDR: begin
                    state_d = F_PC;
                    cnt_d   = '0;
                    byte_d  = word_byte(pc_q, 2'd0);
                end
                F_PC: begin
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = F_INS;
                        cnt_d   = '0;
                        byte_d  = word_byte(ins_q, 2'd0);
                    end else begin
                        byte_d = word_byte(pc_q, cnt_d[1:0]);
                    end
                end
                F_INS: begin
                    if (cnt_q[1:0] == 2'd3) begin
                        state_d = F_REGS;
                        cnt_d   = '0;
                        byte_d  = word_byte(word_q, 2'd0);
                    end else begin
                        byte_d = word_byte(ins_q, cnt_d[1:0]);
                        if (cnt_d[1:0] == 2'd3) sel_d = '0;
                    end
                end
                F_REGS: begin
                    if (cnt_q == REG_LAST) begin
                        state_d = F_CSUM;
                        byte_d  = csum_q;
                    end else begin
                        byte_d = word_byte(word_q, cnt_d[1:0]);
                        if (cnt_d[1:0] == 2'd3 && cnt_d[CNT_W-1:2] != LAST_WORD)
                            sel_d = 5'(cnt_d[CNT_W-1:2] + 1'b1);
                    end
                end
                default: begin
                    // Idle, or checksum just finished: only a new request keeps the line busy.
                    load    = accept;
                    state_d = accept ? F_HDR : F_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        if (accept) begin
            pc_d  = pc_i;
            ins_d = instr_i;
        end
        csum_d = accept ? '0 :
                 (load && (state_d == F_PC || state_d == F_INS || state_d == F_REGS)) ? csum_q ^ byte_d :
                 csum_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= F_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            ins_q   <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            sel_q   <= sel_d;
        end
    end

    uart_tx_serializer #(
        .BAUD_DIV(BAUD_DIV)
    ) u_ser (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .byte_in_i(byte_d),
        .load_i   (load),
        .ready_o  (ready),
        .stop_o   (stop),
        .tx_o     (tx_o)
    );

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx: directed/randomized bench with a mid-bit UART receiver and a frame model.
module tb_debug_dump_tx;

    localparam int BD = 4;
    localparam int BYTE_CYC = 10 * BD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc = '0, instr = '0, reg_data;
    logic [4:0]  reg_sel;
    logic        tx, busy, done;
    logic [31:0] regs [32];
    logic [7:0]  exp_f [138];

    int vecs = 0, errs = 0, cyc = 0;

    always #5 clk = ~clk;
    assign reg_data = regs[reg_sel];

    debug_dump_tx #(.BAUD_DIV(BD), .NUM_REGS(32), .HEADER(8'hA5)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .pc_i(pc), .instr_i(instr),
        .reg_sel_o(reg_sel), .reg_data_i(reg_data), .tx_o(tx), .busy_o(busy), .done_o(done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver: detects a start bit, then samples every bit in its middle cycle.
    logic [7:0] rx_buf [2048];
    int         rx_t [2048];
    int         rx_n = 0, ferr = 0, mon_t = -1, mon_t0 = 0;
    logic [7:0] mon_sh = '0;

    always @(negedge clk) begin
        if (reset) begin
            mon_t <= -1;
        end else if (mon_t < 0) begin
            if (tx === 1'b0) begin
                mon_t  <= 1;
                mon_t0 <= cyc;
            end
        end else begin
            mon_t <= mon_t + 1;
            if (mon_t == BD / 2 && tx !== 1'b0) ferr <= ferr + 1;
            if (mon_t % BD == BD / 2 && mon_t > BD && mon_t < 9 * BD) mon_sh <= {tx, mon_sh[7:1]};
            if (mon_t == 9 * BD + BD / 2) begin
                if (tx !== 1'b1) ferr <= ferr + 1;
                if (rx_n < 2048) begin
                    rx_buf[rx_n] <= mon_sh;
                    rx_t[rx_n]   <= mon_t0;
                end
                rx_n  <= rx_n + 1;
                mon_t <= -1;
            end
        end
    end

    int done_n = 0;
    int done_hist [16];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (done_n < 16) done_hist[done_n] <= cyc + 1;
            done_n <= done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame model: header, PC and INSTR little-endian, registers little-endian, XOR of payload.
    task automatic build(input logic [31:0] p, input logic [31:0] i);
        logic [7:0] x;
        x = '0;
        exp_f[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            exp_f[1 + k] = p[8*k +: 8];
            exp_f[5 + k] = i[8*k +: 8];
        end
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 4; k++) exp_f[9 + 4*r + k] = regs[r][8*k +: 8];
        for (int n = 1; n < 137; n++) x ^= exp_f[n];
        exp_f[137] = x;
    endtask

    task automatic rnd();
        for (int r = 0; r < 32; r++) regs[r] = $urandom;
        pc    = $urandom;
        instr = $urandom;
    endtask

    task automatic check_frame(input int base, input string tag);
        for (int n = 0; n < 138; n++)
            check($sformatf("%s byte%0d", tag, n), {24'd0, rx_buf[(base + n) % 2048]}, {24'd0, exp_f[n]});
        check({tag, " span"}, rx_t[(base + 137) % 2048] - rx_t[base % 2048], 137 * BYTE_CYC);
    endtask

    task automatic wait_done(input int n, input int lim);
        int k;
        k = 0;
        while (done_n < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        check("done timeout", 32'(done_n >= n), 32'd1);
    endtask

    task automatic kick(output int t);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        check("busy on accept", busy, 1);
        check("start bit on accept", tx, 0);
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int t0, base, d0, k;
        logic [31:0] v1;
        for (int r = 0; r < 32; r++) regs[r] = r;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            check("idle tx", tx, 1);
            check("idle busy", busy, 0);
            check("idle done", done, 0);
            check("idle reg_sel", reg_sel, 0);
        end

        // Known frame with Ri = i.
        pc = 32'h10;
        instr = 32'h8C220004;
        build(pc, instr);
        base = rx_n;
        d0 = done_n;
        kick(t0);
        wait_done(d0 + 1, 6000);
        check("f1 done latency", done_hist[d0 % 16] - t0, 5520);
        repeat (3) @(negedge clk);
        check_frame(base, "f1");
        check("f1 csum", {24'd0, rx_buf[(base + 137) % 2048]}, 32'hBA);
        check("f1 done count", done_n - d0, 1);
        check("f1 busy after", busy, 0);
        check("f1 framing", ferr, 0);

        // Requests during a frame are dropped; inputs changed mid-frame must not leak in.
        rnd();
        build(pc, instr);
        base = rx_n;
        d0 = done_n;
        kick(t0);
        while (cyc - t0 < 99) @(negedge clk);
        start = 1'b1;
        pc = $urandom;
        instr = $urandom;
        @(negedge clk) start = 1'b0;
        while (cyc - t0 < 2999) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(d0 + 1, 6000);
        repeat (300) @(negedge clk);
        check("f2 done count", done_n - d0, 1);
        check("f2 byte count", rx_n - base, 138);
        check("f2 busy after", busy, 0);
        check_frame(base, "f2");

        // Start held high: two frames back to back.
        rnd();
        build(pc, instr);
        base = rx_n;
        d0 = done_n;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        wait_done(d0 + 1, 6000);
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_done(d0 + 2, 6000);
        repeat (300) @(negedge clk);
        check("b2b done1", done_hist[d0 % 16] - t0, 5520);
        check("b2b done2", done_hist[(d0 + 1) % 16] - t0, 11040);
        check("b2b done count", done_n - d0, 2);
        check("b2b gap", rx_t[(base + 138) % 2048] - rx_t[(base + 137) % 2048], BYTE_CYC);
        check_frame(base, "b2b1");
        check_frame(base + 138, "b2b2");

        // Reset during byte 50, then a clean frame.
        rnd();
        base = rx_n;
        d0 = done_n;
        kick(t0);
        k = 0;
        while (rx_n - base < 50 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("reached byte 50", 32'(rx_n - base >= 50), 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort tx", tx, 1);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort reg_sel", reg_sel, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("abort no done", done_n - d0, 0);
        check("abort tx idle", tx, 1);
        rnd();
        build(pc, instr);
        base = rx_n;
        kick(t0);
        wait_done(d0 + 1, 6000);
        check("f3 done latency", done_hist[d0 % 16] - t0, 5520);
        repeat (3) @(negedge clk);
        check_frame(base, "f3");

        // R5 changes only while not selected; frame carries the value seen at its sample point.
        rnd();
        v1 = $urandom;
        regs[5] = v1;
        build(pc, instr);
        regs[5] = $urandom;
        base = rx_n;
        d0 = done_n;
        kick(t0);
        repeat (200) @(negedge clk);
        regs[5] = v1;
        k = 0;
        while (reg_sel !== 5'd6 && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check("r5 sel reached 6", reg_sel, 6);
        regs[5] = ~v1;
        wait_done(d0 + 1, 6000);
        repeat (3) @(negedge clk);
        check_frame(base, "r5");
        check("final framing", ferr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
        $fatal(1);
    end

endmodule
